// File: rtl/calc_top.sv
// calc_top: memory-to-memory adder. Sums {B,A} word pairs and packs two sums per write-back buffer.
// Build option CALC_SAT_ADD_EN: sums saturate on unsigned carry-out instead of wrapping.
module calc_top #(
   parameter int unsigned DataSize = 32,
   parameter int unsigned AddrSize = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [AddrSize-1:0]   read_start_addr,
   input  logic [AddrSize-1:0]   read_end_addr,
   input  logic [AddrSize-1:0]   write_start_addr,
   input  logic [AddrSize-1:0]   write_end_addr,
   input  logic                  initialize,
   input  logic [AddrSize-1:0]   initialize_addr,
   input  logic [DataSize-1:0]   initialize_data,
   input  logic                  initialize_loc_sel,
   output logic                  ready,
   output logic [2*DataSize-1:0] rd_data,
   output logic [2*DataSize-1:0] wr_data,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic [AddrSize-1:0]   curr_rd_addr,
   output logic [AddrSize-1:0]   curr_wr_addr,
   output logic                  loc_sel
);

   localparam int unsigned BufW  = 2 * DataSize;
   localparam int unsigned Depth = 2 ** AddrSize;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_END   = 3'd4;

   logic [DataSize-1:0] mem_a [Depth];
   logic [DataSize-1:0] mem_b [Depth];

   logic [2:0]          state_q, state_d;
   logic                ready_q, ready_d;
   logic [BufW-1:0]     rd_data_q, rd_data_d;
   logic [BufW-1:0]     wr_data_q, wr_data_d;
   logic                wr_en_q, wr_en_d;
   logic                rd_en_q, rd_en_d;
   logic [AddrSize-1:0] curr_rd_addr_q, curr_rd_addr_d;
   logic [AddrSize-1:0] curr_wr_addr_q, curr_wr_addr_d;
   logic                loc_sel_q, loc_sel_d;
   logic [BufW-1:0]     buf_q, buf_d;
   logic [AddrSize-1:0] rd_end_q, rd_end_d;
   logic [AddrSize-1:0] wr_start_q, wr_start_d;
   logic [AddrSize-1:0] wr_end_q, wr_end_d;

   logic [DataSize-1:0] sum_c;
   logic [AddrSize-1:0] wr_ofs_c;
   logic [AddrSize-1:0] wr_lim_c;
   logic                wr_in_bound_c;

`ifdef CALC_SAT_ADD_EN
   logic [DataSize:0] sum_wide_c;
   always_comb begin
      sum_wide_c = {1'b0, rd_data_q[DataSize-1:0]} + {1'b0, rd_data_q[BufW-1:DataSize]};
      sum_c      = sum_wide_c[DataSize] ? '1 : sum_wide_c[DataSize-1:0];
   end
`else
   assign sum_c = rd_data_q[DataSize-1:0] + rd_data_q[BufW-1:DataSize];
`endif

   // Write window measured in run order from the latched start, so wrapped ranges work.
   assign wr_ofs_c      = curr_wr_addr_q - wr_start_q;
   assign wr_lim_c      = wr_end_q - wr_start_q;
   assign wr_in_bound_c = (wr_ofs_c <= wr_lim_c);

   always_comb begin
      state_d        = state_q;
      ready_d        = ready_q;
      rd_data_d      = rd_data_q;
      wr_data_d      = wr_data_q;
      wr_en_d        = 1'b0;
      rd_en_d        = 1'b0;
      curr_rd_addr_d = curr_rd_addr_q;
      curr_wr_addr_d = curr_wr_addr_q;
      loc_sel_d      = loc_sel_q;
      buf_d          = buf_q;
      rd_end_d       = rd_end_q;
      wr_start_d     = wr_start_q;
      wr_end_d       = wr_end_q;

      if (rd_en_q) begin
         rd_data_d = {mem_b[curr_rd_addr_q], mem_a[curr_rd_addr_q]};
      end

      case (state_q)
         S_IDLE: begin
            if (!initialize) begin
               curr_rd_addr_d = read_start_addr;
               curr_wr_addr_d = write_start_addr;
               rd_end_d       = read_end_addr;
               wr_start_d     = write_start_addr;
               wr_end_d       = write_end_addr;
               loc_sel_d      = 1'b0;
               rd_en_d        = 1'b1;
               state_d        = S_READ;
            end
         end
         S_READ: begin
            state_d = S_ADD;
         end
         S_ADD: begin
            loc_sel_d = ~loc_sel_q;
            if (loc_sel_q) begin
               buf_d[BufW-1:DataSize] = sum_c;
               state_d                = S_WRITE;
            end else begin
               buf_d[DataSize-1:0] = sum_c;
               if (curr_rd_addr_q == rd_end_q) begin
                  state_d = S_WRITE;
               end else begin
                  curr_rd_addr_d = curr_rd_addr_q + AddrSize'(1);
                  state_d        = S_READ;
               end
            end
            if (state_d == S_WRITE) begin
               wr_en_d   = wr_in_bound_c;
               wr_data_d = buf_d;
            end else begin
               rd_en_d = 1'b1;
            end
         end
         S_WRITE: begin
            buf_d          = '0;
            curr_wr_addr_d = curr_wr_addr_q + AddrSize'(1);
            if (curr_rd_addr_q == rd_end_q) begin
               ready_d = 1'b1;
               state_d = S_END;
            end else begin
               curr_rd_addr_d = curr_rd_addr_q + AddrSize'(1);
               rd_en_d        = 1'b1;
               state_d        = S_READ;
            end
         end
         S_END: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         ready_q        <= 1'b0;
         rd_data_q      <= '0;
         wr_data_q      <= '0;
         wr_en_q        <= 1'b0;
         rd_en_q        <= 1'b0;
         curr_rd_addr_q <= '0;
         curr_wr_addr_q <= '0;
         loc_sel_q      <= 1'b0;
         buf_q          <= '0;
         rd_end_q       <= '0;
         wr_start_q     <= '0;
         wr_end_q       <= '0;
      end else begin
         state_q        <= state_d;
         ready_q        <= ready_d;
         rd_data_q      <= rd_data_d;
         wr_data_q      <= wr_data_d;
         wr_en_q        <= wr_en_d;
         rd_en_q        <= rd_en_d;
         curr_rd_addr_q <= curr_rd_addr_d;
         curr_wr_addr_q <= curr_wr_addr_d;
         loc_sel_q      <= loc_sel_d;
         buf_q          <= buf_d;
         rd_end_q       <= rd_end_d;
         wr_start_q     <= wr_start_d;
         wr_end_q       <= wr_end_d;
      end
   end

   // SRAM banks are never cleared; the direct-initialize write is last so it wins on a collision.
   always_ff @(posedge clk) begin
      if (wr_en_q) begin
         mem_a[curr_wr_addr_q] <= wr_data_q[DataSize-1:0];
         mem_b[curr_wr_addr_q] <= wr_data_q[BufW-1:DataSize];
      end
      if (initialize) begin
         if (initialize_loc_sel) begin
            mem_b[initialize_addr] <= initialize_data;
         end else begin
            mem_a[initialize_addr] <= initialize_data;
         end
      end
   end

   assign ready        = ready_q;
   assign rd_data      = rd_data_q;
   assign wr_data      = wr_data_q;
   assign wr_en        = wr_en_q;
   assign rd_en        = rd_en_q;
   assign curr_rd_addr = curr_rd_addr_q;
   assign curr_wr_addr = curr_wr_addr_q;
   assign loc_sel      = loc_sel_q;

endmodule

// File: tb/tb_calc_top.sv
// tb_calc_top: randomized self-checking bench for calc_top against a sequential memory model.
module tb_calc_top;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] read_start_addr = '0;
   logic [AW-1:0] read_end_addr = '0;
   logic [AW-1:0] write_start_addr = '0;
   logic [AW-1:0] write_end_addr = '0;
   logic          initialize = 1'b0;
   logic [AW-1:0] initialize_addr = '0;
   logic [DW-1:0] initialize_data = '0;
   logic          initialize_loc_sel = 1'b0;
   logic          ready;
   logic [2*DW-1:0] rd_data;
   logic [2*DW-1:0] wr_data;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] curr_rd_addr;
   logic [AW-1:0] curr_wr_addr;
   logic          loc_sel;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cyc_start = 0;

   logic [DW-1:0] ref_a [DEPTH];
   logic [DW-1:0] ref_b [DEPTH];

   logic [4+2*AW+4*DW-1:0] all_outs;
   assign all_outs = {ready, rd_en, wr_en, loc_sel, curr_rd_addr, curr_wr_addr, rd_data, wr_data};

   calc_top #(.DataSize(DW), .AddrSize(AW)) dut (
      .clk(clk), .reset(reset),
      .read_start_addr(read_start_addr), .read_end_addr(read_end_addr),
      .write_start_addr(write_start_addr), .write_end_addr(write_end_addr),
      .initialize(initialize), .initialize_addr(initialize_addr),
      .initialize_data(initialize_data), .initialize_loc_sel(initialize_loc_sel),
      .ready(ready), .rd_data(rd_data), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
      .curr_rd_addr(curr_rd_addr), .curr_wr_addr(curr_wr_addr), .loc_sel(loc_sel)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] add_words(input logic [DW-1:0] x, input logic [DW-1:0] y);
      longint unsigned s;
      s = longint'(x) + longint'(y);
`ifdef CALC_SAT_ADD_EN
      if (s > 64'h0000_0000_FFFF_FFFF) return '1;
`endif
      return DW'(s);
   endfunction

   // Reference: walk the read range in order, flushing a buffer every two sums or at the end.
   task automatic run_model(input logic [AW-1:0] rs, input logic [AW-1:0] re,
                            input logic [AW-1:0] ws, input logic [AW-1:0] we,
                            output int n, output logic [2*DW-1:0] last_buf);
      logic [AW-1:0] a;
      logic [AW-1:0] w;
      logic [DW-1:0] lo;
      logic [DW-1:0] s;
      bit have_lo;
      int limit;
      int written;
      a = rs; w = ws; lo = '0; have_lo = 0; n = 0; written = 0; last_buf = '0;
      limit = int'(AW'(we - ws));
      forever begin
         s = add_words(ref_a[a], ref_b[a]);
         n++;
         if (!have_lo && a != re) begin
            lo = s;
            have_lo = 1;
         end else begin
            last_buf = have_lo ? {s, lo} : {{DW{1'b0}}, s};
            if (written <= limit) begin
               ref_a[w] = last_buf[DW-1:0];
               ref_b[w] = last_buf[2*DW-1:DW];
            end
            written++;
            w++;
            have_lo = 0;
         end
         if (a == re) break;
         a++;
      end
   endtask

   task automatic init_word(input bit bank, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      initialize = 1'b1;
      initialize_loc_sel = bank;
      initialize_addr = addr;
      initialize_data = data;
      @(posedge clk);
      if (bank) ref_b[addr] = data;
      else      ref_a[addr] = data;
      @(negedge clk);
      initialize = 1'b0;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic start_run(input logic [AW-1:0] rs, input logic [AW-1:0] re,
                            input logic [AW-1:0] ws, input logic [AW-1:0] we);
      read_start_addr = rs;
      read_end_addr = re;
      write_start_addr = ws;
      write_end_addr = we;
      reset = 1'b0;
      cyc_start = cyc;
   endtask

   task automatic wait_ready(input string name, input int exp_cycles);
      bit done;
      done = 0;
      for (int i = 0; i < exp_cycles + 40 && !done; i++) begin
         if (ready === 1'b1) done = 1;
         else @(negedge clk);
      end
      if (!done && ready === 1'b1) done = 1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_ready: ready never asserted, expected after %0d cycles", name, exp_cycles);
      end else if ((cyc - cyc_start - 1) !== exp_cycles) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc - cyc_start - 1, exp_cycles);
      end
   endtask

   task automatic check_end(input string name, input int n, input logic [AW-1:0] re,
                            input logic [AW-1:0] ws, input logic [2*DW-1:0] exp_wr);
      logic [AW-1:0] exp_wr_addr;
      exp_wr_addr = ws + AW'((n + 1) / 2);
      checks++;
      if ({ready, rd_en, wr_en} !== 3'b100) begin
         errors++;
         $display("FAIL %s_end_strobes: got ready/rd_en/wr_en=%b, expected 100", name, {ready, rd_en, wr_en});
      end
      checks++;
      if (wr_data !== exp_wr) begin
         errors++;
         $display("FAIL %s_wr_data: got %h, expected %h", name, wr_data, exp_wr);
      end
      checks++;
      if (curr_rd_addr !== re || curr_wr_addr !== exp_wr_addr || loc_sel !== 1'(n % 2)) begin
         errors++;
         $display("FAIL %s_end_addr: got rd=%0d wr=%0d sel=%b, expected rd=%0d wr=%0d sel=%b",
                  name, curr_rd_addr, curr_wr_addr, loc_sel, re, exp_wr_addr, 1'(n % 2));
      end
   endtask

   task automatic check_mem(input string name);
      int bad;
      int first;
      bad = 0;
      first = -1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (dut.mem_a[i] !== ref_a[i] || dut.mem_b[i] !== ref_b[i]) begin
            if (first < 0) first = i;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s_mem: %0d words differ, first at %0d got A=%h B=%h expected A=%h B=%h",
                  name, bad, first, dut.mem_a[first], dut.mem_b[first], ref_a[first], ref_b[first]);
      end
   endtask

   task automatic test_reset();
      int n;
      logic [2*DW-1:0] exp_buf;
      checks++;
      if (all_outs !== '0) begin
         errors++;
         $display("FAIL reset_power_on: got %h, expected all zero", all_outs);
      end
      start_run(AW'(0), AW'(5), AW'(10), AW'(12));
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (all_outs !== '0) begin
         errors++;
         $display("FAIL reset_mid_run: got %h, expected all zero", all_outs);
      end
      // Only the first buffer landed before the abort.
      ref_a[10] = add_words(ref_a[0], ref_b[0]);
      ref_b[10] = add_words(ref_a[1], ref_b[1]);
      check_mem("reset_partial");
      @(negedge clk);
      start_run(AW'(0), AW'(5), AW'(10), AW'(12));
      run_model(AW'(0), AW'(5), AW'(10), AW'(12), n, exp_buf);
      wait_ready("reset_restart", 2 * n + (n + 1) / 2);
      check_end("reset_restart", n, AW'(5), AW'(10), exp_buf);
      check_mem("reset_restart");
   endtask

   task automatic test_basic();
      int n;
      logic [2*DW-1:0] exp_buf;
      hold_reset();
      init_word(0, AW'(0), 32'd1); init_word(0, AW'(1), 32'd3);
      init_word(1, AW'(0), 32'd2); init_word(1, AW'(1), 32'd4);
      start_run(AW'(0), AW'(1), AW'(2), AW'(2));
      run_model(AW'(0), AW'(1), AW'(2), AW'(2), n, exp_buf);
      wait_ready("basic", 5);
      check_end("basic", 2, AW'(1), AW'(2), 64'h00000007_00000003);
      checks++;
      if (dut.mem_a[2] !== 32'd3 || dut.mem_b[2] !== 32'd7) begin
         errors++;
         $display("FAIL basic_addr2: got A=%h B=%h, expected A=3 B=7", dut.mem_a[2], dut.mem_b[2]);
      end
      check_mem("basic");
   endtask

   task automatic test_odd();
      int n;
      logic [2*DW-1:0] exp_buf;
      hold_reset();
      init_word(0, AW'(0), 32'd1); init_word(0, AW'(1), 32'd3); init_word(0, AW'(2), 32'd5);
      init_word(1, AW'(0), 32'd2); init_word(1, AW'(1), 32'd4); init_word(1, AW'(2), 32'd6);
      start_run(AW'(0), AW'(2), AW'(8), AW'(9));
      run_model(AW'(0), AW'(2), AW'(8), AW'(9), n, exp_buf);
      wait_ready("odd", 8);
      check_end("odd", 3, AW'(2), AW'(8), 64'h00000000_0000000B);
      checks++;
      if (dut.mem_a[8] !== 32'd3 || dut.mem_b[8] !== 32'd7 ||
          dut.mem_a[9] !== 32'd11 || dut.mem_b[9] !== 32'd0) begin
         errors++;
         $display("FAIL odd_words: got A8=%h B8=%h A9=%h B9=%h, expected 3 7 b 0",
                  dut.mem_a[8], dut.mem_b[8], dut.mem_a[9], dut.mem_b[9]);
      end
      check_mem("odd");
   endtask

   task automatic test_overflow();
      int n;
      logic [2*DW-1:0] exp_buf;
      logic [DW-1:0] exp_sum;
`ifdef CALC_SAT_ADD_EN
      exp_sum = 32'hFFFF_FFFF;
`else
      exp_sum = 32'h0000_0001;
`endif
      hold_reset();
      init_word(0, AW'(0), 32'hFFFF_FFFF);
      init_word(1, AW'(0), 32'd2);
      start_run(AW'(0), AW'(0), AW'(20), AW'(20));
      run_model(AW'(0), AW'(0), AW'(20), AW'(20), n, exp_buf);
      wait_ready("overflow", 3);
      checks++;
      if (dut.mem_a[20] !== exp_sum || dut.mem_b[20] !== 32'd0) begin
         errors++;
         $display("FAIL overflow_sum: got A=%h B=%h, expected A=%h B=0", dut.mem_a[20], dut.mem_b[20], exp_sum);
      end
      check_mem("overflow");
   endtask

   task automatic test_init_priority();
      int n;
      logic [2*DW-1:0] exp_buf;
      bit seen;
      hold_reset();
      init_word(0, AW'(0), 32'd1); init_word(0, AW'(1), 32'd3);
      init_word(1, AW'(0), 32'd2); init_word(1, AW'(1), 32'd4);
      start_run(AW'(0), AW'(1), AW'(5), AW'(5));
      run_model(AW'(0), AW'(1), AW'(5), AW'(5), n, exp_buf);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (wr_en === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL prio_wr_en: got no write strobe, expected one within 20 cycles");
      end else begin
         initialize = 1'b1;
         initialize_loc_sel = 1'b1;
         initialize_addr = AW'(5);
         initialize_data = 32'h0000_DEAD;
         @(posedge clk);
         @(negedge clk);
         initialize = 1'b0;
         ref_b[5] = 32'h0000_DEAD;
      end
      wait_ready("prio", 5);
      checks++;
      if (dut.mem_a[5] !== 32'd3 || dut.mem_b[5] !== 32'h0000_DEAD) begin
         errors++;
         $display("FAIL prio_addr5: got A=%h B=%h, expected A=3 B=dead", dut.mem_a[5], dut.mem_b[5]);
      end
      check_mem("prio");
   endtask

   task automatic test_write_bound();
      int n;
      logic [2*DW-1:0] exp_buf;
      logic [DW-1:0] keep_a;
      logic [DW-1:0] keep_b;
      hold_reset();
      for (int i = 0; i < 6; i++) begin
         init_word(0, AW'(i), $urandom);
         init_word(1, AW'(i), $urandom);
      end
      keep_a = ref_a[2];
      keep_b = ref_b[2];
      start_run(AW'(0), AW'(5), AW'(0), AW'(1));
      run_model(AW'(0), AW'(5), AW'(0), AW'(1), n, exp_buf);
      wait_ready("bound", 15);
      check_end("bound", 6, AW'(5), AW'(0), exp_buf);
      checks++;
      if (dut.mem_a[2] !== keep_a || dut.mem_b[2] !== keep_b) begin
         errors++;
         $display("FAIL bound_addr2: got A=%h B=%h, expected A=%h B=%h", dut.mem_a[2], dut.mem_b[2], keep_a, keep_b);
      end
      check_mem("bound");
   endtask

   task automatic test_random();
      int n;
      int len;
      logic [2*DW-1:0] exp_buf;
      logic [AW-1:0] rs, re, ws, we;
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, 24);
         rs = (it == 0) ? AW'(1020) : AW'($urandom);
         re = rs + AW'(len - 1);
         ws = AW'($urandom);
         we = ws + AW'($urandom_range(0, len / 2 + 1));
         hold_reset();
         for (int k = 0; k < 4; k++) begin
            init_word(k[0], rs + AW'($urandom_range(0, len - 1)),
                      (k == 0) ? 32'hFFFF_FFF0 : DW'($urandom));
         end
         start_run(rs, re, ws, we);
         run_model(rs, re, ws, we, n, exp_buf);
         wait_ready("random", 2 * len + (len + 1) / 2);
         check_end("random", len, re, ws, exp_buf);
         check_mem("random");
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < int'(DEPTH); i++) begin
         init_word(0, AW'(i), $urandom);
         init_word(1, AW'(i), $urandom);
      end
      test_reset();
      test_basic();
      test_odd();
      test_overflow();
      test_init_priority();
      test_write_bound();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
